// File: rtl/cursor_navegador_pkg.sv
// Shared constants for the 5x5 calculator keypad cursor: grid limits,
// button indices and the key index of every grid cell.
package cursor_navegador_pkg;

    localparam int GRID_MAX  = 4;
    localparam int GRID_COLS = 5;
    localparam int NUM_KEYS  = GRID_COLS * (GRID_MAX + 1);
    localparam int NUM_BTNS  = 5;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_SEL   = 4;

    typedef logic [2:0] gridPos_t;
    typedef logic [4:0] keyIdx_t;

    localparam keyIdx_t KEY_SUMA   = 5'd0;
    localparam keyIdx_t KEY_RESTA  = 5'd1;
    localparam keyIdx_t KEY_MULT   = 5'd2;
    localparam keyIdx_t KEY_DIV    = 5'd3;
    localparam keyIdx_t KEY_IGUAL  = 5'd4;
    localparam keyIdx_t KEY_C_HEX  = 5'd5;
    localparam keyIdx_t KEY_D      = 5'd6;
    localparam keyIdx_t KEY_E      = 5'd7;
    localparam keyIdx_t KEY_F      = 5'd8;
    localparam keyIdx_t KEY_RAIZ   = 5'd9;
    localparam keyIdx_t KEY_8      = 5'd10;
    localparam keyIdx_t KEY_9      = 5'd11;
    localparam keyIdx_t KEY_A      = 5'd12;
    localparam keyIdx_t KEY_B      = 5'd13;
    localparam keyIdx_t KEY_BORRAR = 5'd14;
    localparam keyIdx_t KEY_4      = 5'd15;
    localparam keyIdx_t KEY_5      = 5'd16;
    localparam keyIdx_t KEY_6      = 5'd17;
    localparam keyIdx_t KEY_7      = 5'd18;
    localparam keyIdx_t KEY_AC     = 5'd19;
    localparam keyIdx_t KEY_0      = 5'd20;
    localparam keyIdx_t KEY_1      = 5'd21;
    localparam keyIdx_t KEY_2      = 5'd22;
    localparam keyIdx_t KEY_3      = 5'd23;
    localparam keyIdx_t KEY_C_CLR  = 5'd24;

    // Row-major keypad layout; cell (row, col) sits at row*GRID_COLS + col.
    localparam keyIdx_t KEY_MAP [NUM_KEYS] = '{
        KEY_SUMA,  KEY_RESTA, KEY_MULT, KEY_DIV,   KEY_IGUAL,
        KEY_C_HEX, KEY_D,     KEY_E,    KEY_F,     KEY_RAIZ,
        KEY_8,     KEY_9,     KEY_A,    KEY_B,     KEY_BORRAR,
        KEY_4,     KEY_5,     KEY_6,    KEY_7,     KEY_AC,
        KEY_0,     KEY_1,     KEY_2,    KEY_3,     KEY_C_CLR
    };

endpackage

// File: rtl/cursor_navegador_antirrebote.sv
// One button channel: 2-flop synchronizer, stability-count debouncer and a
// single-cycle pulse on each debounced 0->1 transition.
module antirrebote #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btnRaw,
    output logic pressPulse
);

    logic        syncA;
    logic        syncB;
    logic        stableLvl;
    logic        stableDly;
    logic [15:0] diffCnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            syncA      <= 1'b0;
            syncB      <= 1'b0;
            stableLvl  <= 1'b0;
            stableDly  <= 1'b0;
            pressPulse <= 1'b0;
            diffCnt    <= 16'd0;
        end else begin
            syncA      <= btnRaw;
            syncB      <= syncA;
            stableDly  <= stableLvl;
            pressPulse <= stableLvl & ~stableDly;
            // diffCnt holds how many consecutive samples already disagreed.
            if (syncB == stableLvl) begin
                diffCnt <= 16'd0;
            end else if (diffCnt == DEBOUNCE_CYCLES - 16'd1) begin
                stableLvl <= syncB;
                diffCnt   <= 16'd0;
            end else begin
                diffCnt <= diffCnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/cursor_navegador.sv
// Keypad cursor: debounced buttons move a wrapping 5x5 cursor and the select
// button reports the key under the cursor.
module cursor_navegador
    import cursor_navegador_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_sel,
    output logic [2:0] PosHor,
    output logic [2:0] PosVer,
    output logic [4:0] key_code,
    output logic       key_valid
);

    logic [NUM_BTNS-1:0] btnRaw;
    logic [NUM_BTNS-1:0] btnEvt;
    gridPos_t            horNext;
    gridPos_t            verNext;
    keyIdx_t             keyIdx;

    assign btnRaw = {btn_sel, btn_right, btn_left, btn_down, btn_up};

    for (genvar i = 0; i < NUM_BTNS; i++) begin : gBtn
        antirrebote #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) uAntirrebote (
            .clk       (clk),
            .rst_n     (rst_n),
            .btnRaw    (btnRaw[i]),
            .pressPulse(btnEvt[i])
        );
    end

    // Opposing events in the same cycle cancel; the two axes are independent.
    always_comb begin
        horNext = PosHor;
        verNext = PosVer;
        if (btnEvt[BTN_RIGHT] && !btnEvt[BTN_LEFT]) begin
            horNext = (PosHor >= 3'(GRID_MAX)) ? 3'd0 : PosHor + 3'd1;
        end else if (btnEvt[BTN_LEFT] && !btnEvt[BTN_RIGHT]) begin
            horNext = (PosHor == 3'd0 || PosHor > 3'(GRID_MAX)) ? 3'(GRID_MAX) : PosHor - 3'd1;
        end
        if (btnEvt[BTN_DOWN] && !btnEvt[BTN_UP]) begin
            verNext = (PosVer >= 3'(GRID_MAX)) ? 3'd0 : PosVer + 3'd1;
        end else if (btnEvt[BTN_UP] && !btnEvt[BTN_DOWN]) begin
            verNext = (PosVer == 3'd0 || PosVer > 3'(GRID_MAX)) ? 3'(GRID_MAX) : PosVer - 3'd1;
        end
    end

    // Built from the current (pre-move) position so a select coinciding with a move reports the old cell.
    assign keyIdx = 5'(PosVer) * 5'(GRID_COLS) + 5'(PosHor);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            PosHor    <= 3'd0;
            PosVer    <= 3'd0;
            key_code  <= 5'd0;
            key_valid <= 1'b0;
        end else begin
            PosHor    <= horNext;
            PosVer    <= verNext;
            key_valid <= btnEvt[BTN_SEL];
            if (btnEvt[BTN_SEL]) begin
                key_code <= KEY_MAP[keyIdx];
            end
        end
    end

endmodule

// File: tb/tb_cursor_navegador.sv
// Scoreboard bench for cursor_navegador: stimulus tasks predict cursor moves
// and key reports, a negedge monitor pops and compares as the DUT shows them.
module tb_cursor_navegador;

    localparam int DEB = 4;
    localparam logic [4:0] M_UP = 5'b00001, M_DOWN = 5'b00010, M_LEFT = 5'b00100,
                           M_RIGHT = 5'b01000, M_SEL = 5'b10000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_sel = 1'b0;
    logic [2:0] PosHor, PosVer;
    logic [4:0] key_code;
    logic       key_valid;

    typedef struct {
        bit isKey;
        int a;
        int b;
    } exp_t;

    exp_t expQ[$];
    int   tests = 0;
    int   fails = 0;
    int   modelH = 0, modelV = 0;
    int   lastH = 0, lastV = 0, lastCode = 0;
    logic rstSampled = 1'b1;

    cursor_navegador #(.DEBOUNCE_CYCLES(16'(DEB))) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .btn_sel  (btn_sel),
        .PosHor   (PosHor),
        .PosVer   (PosVer),
        .key_code (key_code),
        .key_valid(key_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rstSampled <= rst_n;

    task automatic popCheck(input bit isKey, input int a, input int b);
        exp_t e;
        tests++;
        if (expQ.size() == 0) begin
            fails++;
            $display("FAIL %s unexpected: got %0d,%0d required nothing", isKey ? "key" : "move", a, b);
        end else begin
            e = expQ.pop_front();
            if (e.isKey != isKey || e.a != a || e.b != b) begin
                fails++;
                $display("FAIL %s: got kind=%0d %0d,%0d required kind=%0d %0d,%0d",
                         isKey ? "key" : "move", isKey, a, b, e.isKey, e.a, e.b);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rstSampled) begin
            tests++;
            if (PosHor !== 3'd0 || PosVer !== 3'd0 || key_code !== 5'd0 || key_valid !== 1'b0) begin
                fails++;
                $display("FAIL reset: got h=%0d v=%0d code=%0d valid=%0d required all 0",
                         PosHor, PosVer, key_code, key_valid);
            end
            lastH = 0; lastV = 0; lastCode = 0;
        end else begin
            if (int'(PosHor) != lastH || int'(PosVer) != lastV) begin
                popCheck(1'b0, int'(PosHor), int'(PosVer));
                lastH = int'(PosHor);
                lastV = int'(PosVer);
            end
            if (key_valid === 1'b1) begin
                popCheck(1'b1, int'(key_code), 0);
            end else begin
                tests++;
                if (int'(key_code) != lastCode) begin
                    fails++;
                    $display("FAIL key_code hold: got %0d required %0d", key_code, lastCode);
                end
            end
            lastCode = int'(key_code);
        end
    end

    task automatic setBtns(input logic [4:0] m);
        btn_up = m[0]; btn_down = m[1]; btn_left = m[2]; btn_right = m[3]; btn_sel = m[4];
    endtask

    // Reference: a clean press of at least DEB cycles yields one event per held button.
    task automatic applyModel(input logic [4:0] m);
        int dh, dv, nh, nv;
        dh = int'(m[3]) - int'(m[2]);
        dv = int'(m[1]) - int'(m[0]);
        nh = (modelH + dh + 5) % 5;
        nv = (modelV + dv + 5) % 5;
        if (nh != modelH || nv != modelV) expQ.push_back('{1'b0, nh, nv});
        if (m[4]) expQ.push_back('{1'b1, modelV * 5 + modelH, 0});
        modelH = nh;
        modelV = nv;
    endtask

    task automatic checkPos(input string tag);
        tests++;
        if (int'(PosHor) != modelH || int'(PosVer) != modelV) begin
            fails++;
            $display("FAIL pos %s: got h=%0d v=%0d required h=%0d v=%0d", tag, PosHor, PosVer, modelH, modelV);
        end
    endtask

    task automatic pressStep(input logic [4:0] m, input int hold, input string tag);
        if (hold >= DEB) applyModel(m);
        setBtns(m);
        repeat (hold) @(posedge clk);
        #1 setBtns(5'b0);
        repeat (12) @(posedge clk);
        #1 checkPos(tag);
    endtask

    task automatic resetStep(input logic [4:0] m, input int pre, input int rstCyc, input int post, input string tag);
        setBtns(m);
        repeat (pre) @(posedge clk);
        #1 rst_n = 1'b0;
        modelH = 0;
        modelV = 0;
        repeat (rstCyc) @(posedge clk);
        #1 rst_n = 1'b1;
        if (post >= DEB) applyModel(m);
        repeat (post) @(posedge clk);
        #1 setBtns(5'b0);
        repeat (12) @(posedge clk);
        #1 checkPos(tag);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        checkPos("after reset");

        for (int i = 0; i < 5; i++) pressStep(M_RIGHT, 6, "right sweep");
        pressStep(M_UP, 6, "up wrap");
        pressStep(M_SEL, 6, "sel row4");
        pressStep(M_DOWN, 3, "down glitch");
        pressStep(M_DOWN, 4, "down min hold");
        pressStep(M_LEFT | M_RIGHT, 6, "left+right");

        resetStep(5'b0, 0, 2, 0, "plain reset");
        pressStep(M_RIGHT, 5, "to 2,2");
        pressStep(M_RIGHT, 5, "to 2,2");
        pressStep(M_DOWN, 5, "to 2,2");
        pressStep(M_DOWN, 5, "to 2,2");
        pressStep(M_UP | M_RIGHT, 6, "up+right");
        pressStep(M_SEL | M_DOWN, 5, "sel+move");
        pressStep(M_LEFT, 5, "left");
        pressStep(M_UP | M_DOWN | M_SEL, 6, "up+down+sel");

        resetStep(M_RIGHT, 3, 2, 0, "reset mid-count");
        resetStep(M_RIGHT, 2, 2, 6, "held through reset");

        for (int i = 0; i < 40; i++) begin
            pressStep(5'($urandom_range(0, 31)), int'($urandom_range(1, 7)), "random");
        end

        repeat (5) @(posedge clk);
        #1 tests++;
        if (expQ.size() != 0) begin
            fails++;
            $display("FAIL missing events: got %0d outstanding required 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
